// File: rtl/inner_slave_rx_if.sv
// inner_iface: one-way valid/data beat channel with no back-pressure.
// The master drives data/valid; the slave only samples them on clk.
interface inner_iface (
    input logic clk
);
    logic [7:0] data;
    logic       valid;

    modport master (input clk, output data, output valid);
    modport slave  (input data, input valid);
endinterface

// File: rtl/inner_slave_rx.sv
// Receive endpoint of inner_iface: buffers every valid beat in a small FWFT FIFO,
// re-emits it on a ready/valid stream and keeps accepted-beat statistics.
module inner_slave_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    inner_iface.slave                ifc,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         count,
    output logic [7:0]               checksum,
    output logic                     overflow,
    input  logic                     clr_stats
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    logic [CNT_W-1:0] count_nxt;
    logic [7:0]       checksum_nxt;
    logic             overflow_nxt;

    // Output stream: a transfer happens at a posedge where out_valid and out_ready
    // are both 1; out_data is held stable while out_valid=1 and out_ready=0.
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

    assign full = (level == LW'(DEPTH));
    assign pop  = out_valid & out_ready;
    // A full FIFO can still take a beat when the head leaves on the same edge.
    assign push = ifc.valid & (~full | pop);
    assign drop = ifc.valid & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ifc.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // clr_stats wipes the old totals first, so a beat on the same edge starts them afresh.
    always_comb begin
        count_nxt    = clr_stats ? '0 : count;
        checksum_nxt = clr_stats ? 8'h00 : checksum;
        overflow_nxt = clr_stats ? 1'b0 : overflow;
        if (push) begin
            if (count_nxt != CNT_MAX) begin
                count_nxt = count_nxt + 1'b1;
            end
            checksum_nxt = checksum_nxt ^ ifc.data;
        end
        if (drop) begin
            overflow_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            checksum <= 8'h00;
            overflow <= 1'b0;
        end else begin
            count    <= count_nxt;
            checksum <= checksum_nxt;
            overflow <= overflow_nxt;
        end
    end
endmodule

// File: doc/inner_slave_rx.md
Name: inner_slave_rx

Overview:
- Receive-side endpoint of the `inner_iface` valid/data protocol. It attaches to the `slave` modport and is the counterpart of any block driving the `master` modport.
- Samples every valid beat into a small first-word-fall-through (FWFT) FIFO and presents the beats on a ready/valid output stream.
- Keeps beat statistics: accepted count, XOR checksum, sticky overflow.
- Instantiable directly or via a hierarchical interface path, e.g. `container.inner`.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  sampling clock; the same clock that drives the interface's clk.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ifc  interface  inner_iface.slave  source of the input fields `ifc.data[7:0]` and `ifc.valid`.
- out_data  output  8  FIFO head byte.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- count  output  CNT_W  number of accepted beats, saturating.
- checksum  output  8  XOR of all accepted beat bytes.
- overflow  output  1  sticky flag: a beat was dropped.
- clr_stats  input  1  synchronous clear of count, checksum and overflow.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n).
- While rst_n=0, all of the following are 0: out_data, out_valid, level, count, checksum, overflow. The FIFO is empty and its pointers are 0. Reset mid-stream discards all stored beats.
- Input sampling: at each posedge clk, if ifc.valid=1 the byte ifc.data is a beat. There is no back-pressure on the input side, because the protocol has none.
- Push: the beat is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Drop: a beat arriving when the FIFO is full with no pop is discarded.
  - overflow is set to 1 and stays 1 until clr_stats or reset.
  - count and checksum do not change.
- Pop: happens when out_valid and out_ready are both 1 at posedge.
- Output stream (FWFT):
  - out_valid = (level != 0).
  - out_data = entry at the read pointer. It holds stable while out_valid=1 and out_ready=0.
  - out_data is don't-care when out_valid=0.
- Latency: a beat sampled at edge N appears on out_valid/out_data after edge N, i.e. in cycle N+1. There is no combinational input-to-output path.
- Simultaneous push and pop: level is unchanged. On an empty FIFO a pop cannot occur, so the push alone applies.
- Pointers are log2(DEPTH) bits and wrap naturally. level counts 0..DEPTH.
- Accept update: count <= count+1, saturating at 2^CNT_W-1; checksum <= checksum ^ data.
- clr_stats=1 at an edge: count, checksum and overflow are cleared.
  - If an accepted beat occurs at the same edge, the result is count=1 and checksum=beat.
  - If a dropped beat occurs at the same edge, the result is overflow=1.
  - The FIFO is never affected by clr_stats.
- ifc.data is ignored when ifc.valid=0.
- This block never drives interface signals.

Test Plan:
- Single beat: reset, then one cycle of valid=1, data=8'hAB, with out_ready=0 → next cycle out_valid=1, out_data=AB, level=1, count=1, checksum=AB. The values hold until out_ready=1, after which out_valid=0 and level=0.
- Fill and overflow, DEPTH=4, out_ready=0: beats 01,02,03,04,05 back-to-back → level=4, count=4, checksum=04, overflow=1. Draining then yields 01,02,03,04 in order.
- Full with simultaneous push/pop: FIFO full with 10..13; next edge has beat 14 and out_ready=1 → pops 10, level stays 4, overflow=0, count=5. Draining yields 11,12,13,14.
- Wrap-around: 10 push/pop pairs of 00..09 at level 1 → order preserved across pointer wrap, checksum=01, count=10.
- Statistics clear: clr_stats asserted on the same edge as beat 5A → count=1, checksum=5A, overflow=0, FIFO contents retained. Separately, CNT_W=2 with 5 beats → count saturates at 3.
- Reset mid-operation: with level=3 and overflow=1, pulse rst_n low asynchronously (between edges) → out_valid, level, count, checksum and overflow are 0 immediately. After release, the next beat 77 produces out_data=77 and count=1.
